// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative CORDIC vectoring engine: (x, y) to magnitude x An and atan2 angle
module cordic_vectoring #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16,
    parameter int GUARD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH+GUARD-1:0]  mag,
    output logic [WIDTH-1:0]        angle
);

    localparam int DW = WIDTH + GUARD;
    localparam int CW = $clog2(ITER + 1);

    // Binary angle scale: full circle = 2^16, so a quarter turn is 16'h4000.
    localparam logic [15:0] ATAN [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };
    localparam logic [WIDTH-1:0] QUARTER = WIDTH'(16'h4000);

    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic signed [DW-1:0]  r_x;
    logic signed [DW-1:0]  r_y;
    logic [WIDTH-1:0]      r_z;
    logic [CW-1:0]         r_i;
    logic [DW-1:0]         r_mag;
    logic [WIDTH-1:0]      r_angle;

    logic                  w_accept;
    logic                  w_last;
    logic signed [DW-1:0]  w_xe;
    logic signed [DW-1:0]  w_ye;
    logic signed [DW-1:0]  w_x0;
    logic signed [DW-1:0]  w_y0;
    logic [WIDTH-1:0]      w_z0;
    logic signed [DW-1:0]  w_xs;
    logic signed [DW-1:0]  w_ys;
    logic [3:0]            w_idx;
    logic [WIDTH-1:0]      w_atan;
    logic signed [DW-1:0]  w_xn;
    logic signed [DW-1:0]  w_yn;
    logic [WIDTH-1:0]      w_zn;

    // A new request is taken from IDLE or from the DONE cycle (back-to-back), never while rotating.
    assign w_accept = start && (r_state != S_ROTATE);
    assign w_last   = (r_i == CW'(ITER - 1));

    assign w_xe = {{GUARD{x_in[WIDTH-1]}}, x_in};
    assign w_ye = {{GUARD{y_in[WIDTH-1]}}, y_in};

    // Quadrant pre-rotation folds the left half-plane into the right; negation at DW bits keeps -32768 exact.
    always_comb begin
        w_x0 = w_xe;
        w_y0 = w_ye;
        w_z0 = '0;
        if (w_xe[DW-1]) begin
            if (!w_ye[DW-1]) begin
                w_x0 = w_ye;
                w_y0 = -w_xe;
                w_z0 = QUARTER;
            end else begin
                w_x0 = -w_ye;
                w_y0 = w_xe;
                w_z0 = -QUARTER;
            end
        end
    end

    assign w_xs   = r_x >>> r_i;
    assign w_ys   = r_y >>> r_i;
    assign w_idx  = 4'(r_i);
    assign w_atan = WIDTH'(ATAN[w_idx]);

    // One micro-rotation driving y toward zero; y == 0 counts as non-negative.
    always_comb begin
        if (!r_y[DW-1]) begin
            w_xn = r_x + w_ys;
            w_yn = r_y - w_xs;
            w_zn = r_z + w_atan;
        end else begin
            w_xn = r_x - w_ys;
            w_yn = r_y + w_xs;
            w_zn = r_z - w_atan;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_ROTATE;
            S_ROTATE: if (w_last) w_next = S_DONE;
            S_DONE:   w_next = start ? S_ROTATE : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (r_state == S_ROTATE);
        done = (r_state == S_DONE);
    end

    // Datapath: operand capture, iteration, and result registers that hold until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            r_mag   <= '0;
            r_angle <= '0;
        end else if (w_accept) begin
            r_x <= w_x0;
            r_y <= w_y0;
            r_z <= w_z0;
            r_i <= '0;
        end else if (r_state == S_ROTATE) begin
            r_x <= w_xn;
            r_y <= w_yn;
            r_z <= w_zn;
            r_i <= r_i + CW'(1);
            if (w_last) begin
                r_mag   <= w_xn;
                r_angle <= w_zn;
            end
        end
    end

    assign mag   = r_mag;
    assign angle = r_angle;

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - self-checking bench for cordic_vectoring against an ideal atan2/hypot model
module tb_cordic_vectoring;

    localparam int  WIDTH = 16;
    localparam int  ITER  = 16;
    localparam int  GUARD = 2;
    localparam real AN    = 1.6467602581210656;
    localparam real PI    = 3.141592653589793;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic signed [WIDTH-1:0]  x_in;
    logic signed [WIDTH-1:0]  y_in;
    logic                     busy;
    logic                     done;
    logic [WIDTH+GUARD-1:0]   mag;
    logic [WIDTH-1:0]         angle;

    int n_checks = 0;
    int n_errors = 0;

    cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .mag   (mag),
        .angle (angle)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_angle(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        logic signed [15:0] d;
        d = obs - exp;
        n_checks++;
        assert ((d >= -16'sd4) && (d <= 16'sd4)) else begin
            n_errors++;
            $error("FAIL %s: observed angle 0x%04h, expected 0x%04h +/-4", tag, obs, exp);
        end
    endtask

    task automatic check_mag(input string tag, input int obs, input real exp);
        real d;
        d = real'(obs) - exp;
        n_checks++;
        assert ((d >= -8.0) && (d <= 8.0)) else begin
            n_errors++;
            $error("FAIL %s: observed mag %0d, expected %0d +/-8", tag, obs, $rtoi(exp + 0.5));
        end
    endtask

    // Ideal polar result of (xv, yv): angle in binary units (full circle 2^16), magnitude times An.
    task automatic check_result(input string tag, input int xv, input int yv);
        real         m;
        real         a;
        int          ai;
        logic [15:0] ae;
        m  = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)) * AN;
        a  = $atan2(real'(yv), real'(xv)) * 32768.0 / PI;
        ai = $rtoi($floor(a + 0.5));
        ae = 16'(ai);
        check_angle({tag, "_angle"}, angle, ae);
        check_mag({tag, "_mag"}, int'(mag), m);
    endtask

    // Waits for done; optionally pulses start with new operands after edge inject_at.
    task automatic wait_done(input int inject_at, input int ix, input int iy, output int cycles);
        cycles = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                cycles = k;
                break;
            end
            if (k == inject_at) begin
                start = 1'b1;
                x_in  = 16'(ix);
                y_in  = 16'(iy);
            end
        end
    endtask

    task automatic launch(input int xv, input int yv);
        x_in  = 16'(xv);
        y_in  = 16'(yv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input string tag, input int xv, input int yv);
        int cyc;
        launch(xv, yv);
        check_eq({tag, "_busy"}, int'(busy), 1);
        wait_done(0, 0, 0, cyc);
        check_eq({tag, "_latency"}, cyc, ITER);
        check_result(tag, xv, yv);
    endtask

    initial begin
        int cyc;
        int pulses;
        int rx;
        int ry;

        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy",  int'(busy),  0);
        check_eq("reset_done",  int'(done),  0);
        check_eq("reset_mag",   int'(mag),   0);
        check_eq("reset_angle", int'(angle), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_vec("diag", 16384, 16384);
        @(posedge clk);
        #1;
        check_eq("diag_done_one_cycle", int'(done), 0);
        check_eq("diag_idle_busy",      int'(busy), 0);
        check_eq("diag_mag_hold",       (int'(mag) > 38000) ? 1 : 0, 1);

        run_vec("neg_y_axis", 0, -16384);
        run_vec("wrap_180",   -16384, 0);
        run_vec("q3_extreme", -32768, -32768);

        launch(1000, 2000);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_busy",  int'(busy),  0);
        check_eq("midrst_done",  int'(done),  0);
        check_eq("midrst_mag",   int'(mag),   0);
        check_eq("midrst_angle", int'(angle), 0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check_eq("midrst_no_done", pulses, 0);

        launch(0, 0);
        wait_done(0, 0, 0, cyc);
        check_eq("zero_latency", cyc, ITER);
        check_eq("zero_no_x",    $isunknown({mag, angle}) ? 1 : 0, 0);
        check_eq("zero_mag_le4", (int'(mag) <= 4) ? 1 : 0, 1);

        launch(12000, -7000);
        wait_done(5, -20000, 3000, cyc);
        check_eq("hs_ignore_latency", cyc, ITER);
        check_result("hs_ignore", 12000, -7000);
        x_in  = 16'(-5000);
        y_in  = 16'(25000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("hs_b2b_busy", int'(busy), 1);
        wait_done(0, 0, 0, cyc);
        check_eq("hs_b2b_latency", cyc, ITER);
        check_result("hs_b2b", -5000, 25000);

        for (int n = 0; n < 24; n++) begin
            do begin
                rx = int'($urandom_range(65535)) - 32768;
                ry = int'($urandom_range(65535)) - 32768;
            end while (((rx < 0 ? -rx : rx) < 4096) && ((ry < 0 ? -ry : ry) < 4096));
            run_vec($sformatf("rand%0d", n), rx, ry);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
